// File: rtl/trap_controller_pkg.sv
// Shared definitions for the machine-mode trap sequencer: CSR addresses, cause codes,
// mstatus field positions, state encoding and the mstatus update rules.
package trap_controller_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
    localparam logic [3:0] CAUSE_EBREAK  = 4'd3;
    localparam logic [3:0] CAUSE_ECALL   = 4'd11;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_T_MTVEC    = 4'd1,
        ST_T_MEPC     = 4'd2,
        ST_T_MCAUSE   = 4'd3,
        ST_T_MTVAL    = 4'd4,
        ST_T_MSTAT_RD = 4'd5,
        ST_T_MSTAT_WR = 4'd6,
        ST_REDIRECT   = 4'd7,
        ST_R_MEPC     = 4'd8,
        ST_R_MSTAT_RD = 4'd9,
        ST_R_MSTAT_WR = 4'd10
    } state_e;

    typedef struct packed {
        logic       is_trap;
        logic       is_mret;
        logic [3:0] cause;
    } trap_event_t;

    function automatic logic [31:0] mstatus_on_trap(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        r[MSTATUS_MPIE] = s[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    // M-mode only, so MPP is always left at machine mode on return as well.
    function automatic logic [31:0] mstatus_on_mret(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

endpackage

// File: rtl/trap_cause_encode.sv
// Priority encoder from decoded trap flags to the event to sequence.
// Any synchronous exception outranks MRET; illegal > EBREAK > ECALL.
module trap_cause_encode
    import trap_controller_pkg::*;
(
    input  logic        i_EnvironmentCall,
    input  logic        i_EnvironmentBreak,
    input  logic        i_ReturnFromTrap,
    input  logic        i_IllegalInstruction,
    output trap_event_t o_Event
);

    always_comb begin
        o_Event = '0;
        if (i_IllegalInstruction) begin
            o_Event.is_trap = 1'b1;
            o_Event.cause   = CAUSE_ILLEGAL;
        end else if (i_EnvironmentBreak) begin
            o_Event.is_trap = 1'b1;
            o_Event.cause   = CAUSE_EBREAK;
        end else if (i_EnvironmentCall) begin
            o_Event.is_trap = 1'b1;
            o_Event.cause   = CAUSE_ECALL;
        end else if (i_ReturnFromTrap) begin
            o_Event.is_mret = 1'b1;
        end
    end

endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap entry / MRET sequencer: stalls execute, walks the CSR port, redirects fetch.
//
// state         | meaning
// IDLE          | waiting for a valid trap/MRET in execute
// T_MTVEC       | read mtvec, keep direct-mode base
// T_MEPC        | write mepc with faulting PC
// T_MCAUSE      | write mcause
// T_MTVAL       | write mtval
// T_MSTAT_RD    | read mstatus
// T_MSTAT_WR    | write mstatus with interrupts disabled
// REDIRECT      | redirect fetch to trap vector or saved mepc
// R_MEPC        | read mepc as return target
// R_MSTAT_RD    | read mstatus
// R_MSTAT_WR    | write mstatus with interrupt enable restored
module trap_controller
    import trap_controller_pkg::*;
#(
    parameter int XLEN               = 32,
    parameter bit MTVAL_ILLEGAL_INSN = 1'b1
) (
    input  logic            i_Clock,
    input  logic            i_Reset,
    input  logic            i_Valid,
    input  logic [XLEN-1:0] i_PC,
    input  logic [XLEN-1:0] i_InstructionWord,
    input  logic            i_EnvironmentCall,
    input  logic            i_EnvironmentBreak,
    input  logic            i_ReturnFromTrap,
    input  logic            i_IllegalInstruction,
    input  logic [XLEN-1:0] i_CsrReadData,
    output logic            o_Stall,
    output logic [11:0]     o_CsrNumber,
    output logic            o_CsrReadEnable,
    output logic            o_CsrWriteEnable,
    output logic [XLEN-1:0] o_CsrWriteData,
    output logic            o_Redirect,
    output logic [XLEN-1:0] o_RedirectPC,
    output logic            o_TrapEntered
);

    trap_event_t     evt;
    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] insn_q;
    logic [XLEN-1:0] target_q;
    logic [XLEN-1:0] mstatus_q;
    logic [3:0]      cause_q;
    logic            trap_path_q;
    logic [XLEN-1:0] mtval_value;
    logic            accept;
    logic            busy;

    trap_cause_encode u_cause_encode (
        .i_EnvironmentCall    (i_EnvironmentCall),
        .i_EnvironmentBreak   (i_EnvironmentBreak),
        .i_ReturnFromTrap     (i_ReturnFromTrap),
        .i_IllegalInstruction (i_IllegalInstruction),
        .o_Event              (evt)
    );

    assign accept = !i_Reset && (state_q == ST_IDLE) && i_Valid && (evt.is_trap || evt.is_mret);

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = evt.is_trap ? ST_T_MTVEC : ST_R_MEPC;
                end
            end
            ST_T_MTVEC:    state_d = ST_T_MEPC;
            ST_T_MEPC:     state_d = ST_T_MCAUSE;
            ST_T_MCAUSE:   state_d = ST_T_MTVAL;
            ST_T_MTVAL:    state_d = ST_T_MSTAT_RD;
            ST_T_MSTAT_RD: state_d = ST_T_MSTAT_WR;
            ST_T_MSTAT_WR: state_d = ST_REDIRECT;
            ST_R_MEPC:     state_d = ST_R_MSTAT_RD;
            ST_R_MSTAT_RD: state_d = ST_R_MSTAT_WR;
            ST_R_MSTAT_WR: state_d = ST_REDIRECT;
            default:       state_d = ST_IDLE;
        endcase
    end

    // Event context and CSR read results captured along the sequence.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            pc_q        <= '0;
            insn_q      <= '0;
            cause_q     <= '0;
            trap_path_q <= 1'b0;
            target_q    <= '0;
            mstatus_q   <= '0;
        end else begin
            if (accept) begin
                pc_q        <= i_PC;
                insn_q      <= i_InstructionWord;
                cause_q     <= evt.cause;
                trap_path_q <= evt.is_trap;
            end
            if (state_q == ST_T_MTVEC || state_q == ST_R_MEPC) begin
                target_q <= {i_CsrReadData[XLEN-1:2], 2'b00};
            end
            if (state_q == ST_T_MSTAT_RD || state_q == ST_R_MSTAT_RD) begin
                mstatus_q <= i_CsrReadData;
            end
        end
    end

    always_comb begin
        case (cause_q)
            CAUSE_ILLEGAL: mtval_value = MTVAL_ILLEGAL_INSN ? insn_q : '0;
            CAUSE_EBREAK:  mtval_value = pc_q;
            default:       mtval_value = '0;
        endcase
    end

    // Outputs are forced quiet while reset is asserted so an aborted sequence issues nothing further.
    always_comb begin
        busy             = 1'b0;
        o_CsrNumber      = '0;
        o_CsrReadEnable  = 1'b0;
        o_CsrWriteEnable = 1'b0;
        o_CsrWriteData   = '0;
        o_Redirect       = 1'b0;
        o_RedirectPC     = '0;
        o_TrapEntered    = 1'b0;
        if (!i_Reset) begin
            case (state_q)
                ST_T_MTVEC: begin
                    busy            = 1'b1;
                    o_CsrNumber     = CSR_MTVEC;
                    o_CsrReadEnable = 1'b1;
                end
                ST_T_MEPC: begin
                    busy             = 1'b1;
                    o_CsrNumber      = CSR_MEPC;
                    o_CsrWriteEnable = 1'b1;
                    o_CsrWriteData   = {pc_q[XLEN-1:2], 2'b00};
                end
                ST_T_MCAUSE: begin
                    busy             = 1'b1;
                    o_CsrNumber      = CSR_MCAUSE;
                    o_CsrWriteEnable = 1'b1;
                    o_CsrWriteData   = {{(XLEN-4){1'b0}}, cause_q};
                end
                ST_T_MTVAL: begin
                    busy             = 1'b1;
                    o_CsrNumber      = CSR_MTVAL;
                    o_CsrWriteEnable = 1'b1;
                    o_CsrWriteData   = mtval_value;
                end
                ST_T_MSTAT_RD, ST_R_MSTAT_RD: begin
                    busy            = 1'b1;
                    o_CsrNumber     = CSR_MSTATUS;
                    o_CsrReadEnable = 1'b1;
                end
                ST_T_MSTAT_WR: begin
                    busy             = 1'b1;
                    o_CsrNumber      = CSR_MSTATUS;
                    o_CsrWriteEnable = 1'b1;
                    o_CsrWriteData   = mstatus_on_trap(mstatus_q);
                end
                ST_R_MEPC: begin
                    busy            = 1'b1;
                    o_CsrNumber     = CSR_MEPC;
                    o_CsrReadEnable = 1'b1;
                end
                ST_R_MSTAT_WR: begin
                    busy             = 1'b1;
                    o_CsrNumber      = CSR_MSTATUS;
                    o_CsrWriteEnable = 1'b1;
                    o_CsrWriteData   = mstatus_on_mret(mstatus_q);
                end
                ST_REDIRECT: begin
                    busy          = 1'b1;
                    o_Redirect    = 1'b1;
                    o_RedirectPC  = target_q;
                    o_TrapEntered = trap_path_q;
                end
                default: ;
            endcase
        end
    end

    assign o_Stall = accept || busy;

endmodule

// File: tb/tb_trap_controller.sv
// Scoreboard bench for trap_controller: two instances (mtval gets insn word / gets zero)
// share stimulus, each backed by a small CSR model; observed CSR/redirect events are matched in order.
module tb_trap_controller;

    typedef struct packed {
        logic [2:0]  kind;
        logic [11:0] num;
        logic [31:0] data;
        logic [31:0] cyc;
        logic        te;
    } ev_t;

    localparam logic [2:0] K_RD  = 3'b100;
    localparam logic [2:0] K_WR  = 3'b010;
    localparam logic [2:0] K_RDR = 3'b001;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic valid = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] insn = '0;
    logic ecall = 1'b0, ebreak = 1'b0, mret = 1'b0, ill = 1'b0;

    logic [1:0]       stall, re, we, redir, te;
    logic [1:0][11:0] num;
    logic [1:0][31:0] wdata, rpc, rdata;

    logic        load = 1'b0;
    logic [31:0] ld_status = '0, ld_tvec = '0, ld_epc = '0;
    logic [31:0] m_status [2];
    logic [31:0] m_tvec [2];
    logic [31:0] m_epc [2];

    int cyc = 0;
    int stall_cnt0 = 0;
    ev_t obs0[$], obs1[$], exp0[$], exp1[$];
    int rd0 = 0, rd1 = 0;
    int checks = 0, passed = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    trap_controller #(.XLEN(32), .MTVAL_ILLEGAL_INSN(1'b1)) u_dut (
        .i_Clock(clk), .i_Reset(rst), .i_Valid(valid), .i_PC(pc), .i_InstructionWord(insn),
        .i_EnvironmentCall(ecall), .i_EnvironmentBreak(ebreak), .i_ReturnFromTrap(mret),
        .i_IllegalInstruction(ill), .i_CsrReadData(rdata[0]), .o_Stall(stall[0]),
        .o_CsrNumber(num[0]), .o_CsrReadEnable(re[0]), .o_CsrWriteEnable(we[0]),
        .o_CsrWriteData(wdata[0]), .o_Redirect(redir[0]), .o_RedirectPC(rpc[0]),
        .o_TrapEntered(te[0])
    );

    trap_controller #(.XLEN(32), .MTVAL_ILLEGAL_INSN(1'b0)) u_dut_nz (
        .i_Clock(clk), .i_Reset(rst), .i_Valid(valid), .i_PC(pc), .i_InstructionWord(insn),
        .i_EnvironmentCall(ecall), .i_EnvironmentBreak(ebreak), .i_ReturnFromTrap(mret),
        .i_IllegalInstruction(ill), .i_CsrReadData(rdata[1]), .o_Stall(stall[1]),
        .o_CsrNumber(num[1]), .o_CsrReadEnable(re[1]), .o_CsrWriteEnable(we[1]),
        .o_CsrWriteData(wdata[1]), .o_Redirect(redir[1]), .o_RedirectPC(rpc[1]),
        .o_TrapEntered(te[1])
    );

    always_comb begin
        rdata = '0;
        for (int g = 0; g < 2; g++) begin
            case (num[g])
                12'h300: rdata[g] = m_status[g];
                12'h305: rdata[g] = m_tvec[g];
                12'h341: rdata[g] = m_epc[g];
                default: rdata[g] = '0;
            endcase
        end
    end

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (load) begin
                m_status[g] <= ld_status;
                m_tvec[g]   <= ld_tvec;
                m_epc[g]    <= ld_epc;
            end else if (we[g]) begin
                case (num[g])
                    12'h300: m_status[g] <= wdata[g];
                    12'h305: m_tvec[g]   <= wdata[g];
                    12'h341: m_epc[g]    <= wdata[g];
                    default: ;
                endcase
            end
        end
    end

    function automatic ev_t mk_obs(input int g);
        ev_t e;
        e.kind = {re[g], we[g], redir[g]};
        e.num  = (re[g] || we[g]) ? num[g] : 12'h000;
        e.data = we[g] ? wdata[g] : (redir[g] ? rpc[g] : 32'h0);
        e.cyc  = cyc;
        e.te   = te[g];
        return e;
    endfunction

    always @(negedge clk) begin
        if (re[0] || we[0] || redir[0]) obs0.push_back(mk_obs(0));
        if (re[1] || we[1] || redir[1]) obs1.push_back(mk_obs(1));
        if (stall[0]) stall_cnt0++;
    end

    function automatic ev_t ev(input logic [2:0] k, input logic [11:0] n, input logic [31:0] d,
                               input int c, input logic t);
        ev_t e;
        e.kind = k; e.num = n; e.data = d; e.cyc = c; e.te = t;
        return e;
    endfunction

    function automatic logic [31:0] exp_ms_trap(input logic [31:0] s);
        return (s & ~32'h0000_1888) | (s[3] ? 32'h80 : 32'h0) | 32'h0000_1800;
    endfunction

    function automatic logic [31:0] exp_ms_mret(input logic [31:0] s);
        return (s & ~32'h0000_1888) | (s[7] ? 32'h8 : 32'h0) | 32'h0000_1880;
    endfunction

    function automatic void add(input bit d1, input ev_t e);
        if (d1) exp1.push_back(e);
        else exp0.push_back(e);
    endfunction

    function automatic void exp_trap(input bit d1, input logic [31:0] p, input logic [3:0] cause,
                                     input logic [31:0] tval, input logic [31:0] tvec,
                                     input logic [31:0] ms, input int acc);
        add(d1, ev(K_RD,  12'h305, 32'h0, acc + 1, 1'b0));
        add(d1, ev(K_WR,  12'h341, p & ~32'h3, acc + 2, 1'b0));
        add(d1, ev(K_WR,  12'h342, {28'h0, cause}, acc + 3, 1'b0));
        add(d1, ev(K_WR,  12'h343, tval, acc + 4, 1'b0));
        add(d1, ev(K_RD,  12'h300, 32'h0, acc + 5, 1'b0));
        add(d1, ev(K_WR,  12'h300, exp_ms_trap(ms), acc + 6, 1'b0));
        add(d1, ev(K_RDR, 12'h000, tvec & ~32'h3, acc + 7, 1'b1));
    endfunction

    function automatic void exp_mret(input bit d1, input logic [31:0] epc, input logic [31:0] ms,
                                     input int acc);
        add(d1, ev(K_RD,  12'h341, 32'h0, acc + 1, 1'b0));
        add(d1, ev(K_RD,  12'h300, 32'h0, acc + 2, 1'b0));
        add(d1, ev(K_WR,  12'h300, exp_ms_mret(ms), acc + 3, 1'b0));
        add(d1, ev(K_RDR, 12'h000, epc & ~32'h3, acc + 4, 1'b0));
    endfunction

    task automatic set_models(input logic [31:0] tvec, input logic [31:0] ms, input logic [31:0] epc);
        @(posedge clk); #1;
        ld_tvec = tvec; ld_status = ms; ld_epc = epc; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    // flags order: {illegal, ebreak, ecall, mret}; acc is the accept cycle
    task automatic issue(input logic [31:0] p, input logic [31:0] w, input logic [3:0] f, output int acc);
        @(posedge clk); #1;
        pc = p; insn = w; {ill, ebreak, ecall, mret} = f; valid = 1'b1; acc = cyc;
        @(posedge clk); #1;
        valid = 1'b0; {ill, ebreak, ecall, mret} = 4'b0000;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b1; ecall = 1'b1; pc = 32'h10;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({stall, re, we, redir, te, num, wdata, rpc} !== '0)
            $display("FAIL reset_held outputs: got %h, expected 0", {stall, re, we, redir, te, num, wdata, rpc});
        else passed++;
        @(posedge clk); #1;
        rst = 1'b0; valid = 1'b0; ecall = 1'b0;
        @(negedge clk);
        checks++;
        if ({stall, re, we, redir, te, num, wdata, rpc} !== '0)
            $display("FAIL reset_idle outputs: got %h, expected 0", {stall, re, we, redir, te, num, wdata, rpc});
        else passed++;
        checks++;
        if (obs0.size() != 0) $display("FAIL reset_events: got %0d events, expected 0", obs0.size());
        else passed++;
        rd0 = obs0.size(); rd1 = obs1.size();
    endtask

    task automatic test_ecall();
        int acc, s0;
        ev_t e, o;
        set_models(32'h0000_0201, 32'h0000_0008, 32'h0);
        s0 = stall_cnt0;
        issue(32'h0000_0100, 32'h0000_0073, 4'b0010, acc);
        exp_trap(1'b0, 32'h100, 4'd11, 32'h0, 32'h201, 32'h8, acc);
        repeat (10) @(posedge clk); #1;
        while (exp0.size() > 0) begin
            e = exp0.pop_front(); checks++;
            if (rd0 >= obs0.size())
                $display("FAIL ecall_event: got none, expected kind=%b csr=%h data=%h cyc=%0d", e.kind, e.num, e.data, e.cyc);
            else begin
                o = obs0[rd0]; rd0++;
                if (o !== e) $display("FAIL ecall_event: got kind=%b csr=%h data=%h cyc=%0d te=%b, expected kind=%b csr=%h data=%h cyc=%0d te=%b",
                                      o.kind, o.num, o.data, o.cyc, o.te, e.kind, e.num, e.data, e.cyc, e.te);
                else passed++;
            end
        end
        checks++;
        if (obs0.size() != rd0) begin
            $display("FAIL ecall_extra: got %0d extra events, expected 0", obs0.size() - rd0);
            rd0 = obs0.size();
        end else passed++;
        checks++;
        if (stall_cnt0 - s0 != 8) $display("FAIL ecall_stall_cycles: got %0d, expected 8", stall_cnt0 - s0);
        else passed++;
        rd1 = obs1.size();
    endtask

    task automatic test_illegal();
        int acc;
        ev_t e, o;
        set_models(32'h0000_0201, 32'h0000_0008, 32'h0);
        issue(32'h0000_0044, 32'hFFFF_FFFF, 4'b1000, acc);
        exp_trap(1'b0, 32'h44, 4'd2, 32'hFFFF_FFFF, 32'h201, 32'h8, acc);
        exp_trap(1'b1, 32'h44, 4'd2, 32'h0, 32'h201, 32'h8, acc);
        repeat (10) @(posedge clk); #1;
        while (exp0.size() > 0) begin
            e = exp0.pop_front(); checks++;
            if (rd0 >= obs0.size())
                $display("FAIL illegal_event: got none, expected kind=%b csr=%h data=%h cyc=%0d", e.kind, e.num, e.data, e.cyc);
            else begin
                o = obs0[rd0]; rd0++;
                if (o !== e) $display("FAIL illegal_event: got kind=%b csr=%h data=%h cyc=%0d te=%b, expected kind=%b csr=%h data=%h cyc=%0d te=%b",
                                      o.kind, o.num, o.data, o.cyc, o.te, e.kind, e.num, e.data, e.cyc, e.te);
                else passed++;
            end
        end
        while (exp1.size() > 0) begin
            e = exp1.pop_front(); checks++;
            if (rd1 >= obs1.size())
                $display("FAIL illegal_zero_mtval_event: got none, expected kind=%b csr=%h data=%h cyc=%0d", e.kind, e.num, e.data, e.cyc);
            else begin
                o = obs1[rd1]; rd1++;
                if (o !== e) $display("FAIL illegal_zero_mtval_event: got kind=%b csr=%h data=%h cyc=%0d te=%b, expected kind=%b csr=%h data=%h cyc=%0d te=%b",
                                      o.kind, o.num, o.data, o.cyc, o.te, e.kind, e.num, e.data, e.cyc, e.te);
                else passed++;
            end
        end
        checks++;
        if (obs0.size() != rd0 || obs1.size() != rd1) begin
            $display("FAIL illegal_extra: got %0d/%0d extra events, expected 0/0", obs0.size() - rd0, obs1.size() - rd1);
            rd0 = obs0.size(); rd1 = obs1.size();
        end else passed++;
    endtask

    task automatic test_mret();
        int acc, s0;
        ev_t e, o;
        set_models(32'h0000_0201, 32'h0000_1880, 32'h0000_0107);
        s0 = stall_cnt0;
        issue(32'h0000_0300, 32'h3020_0073, 4'b0001, acc);
        exp_mret(1'b0, 32'h107, 32'h1880, acc);
        repeat (8) @(posedge clk); #1;
        while (exp0.size() > 0) begin
            e = exp0.pop_front(); checks++;
            if (rd0 >= obs0.size())
                $display("FAIL mret_event: got none, expected kind=%b csr=%h data=%h cyc=%0d", e.kind, e.num, e.data, e.cyc);
            else begin
                o = obs0[rd0]; rd0++;
                if (o !== e) $display("FAIL mret_event: got kind=%b csr=%h data=%h cyc=%0d te=%b, expected kind=%b csr=%h data=%h cyc=%0d te=%b",
                                      o.kind, o.num, o.data, o.cyc, o.te, e.kind, e.num, e.data, e.cyc, e.te);
                else passed++;
            end
        end
        checks++;
        if (obs0.size() != rd0) begin
            $display("FAIL mret_extra: got %0d extra events, expected 0", obs0.size() - rd0);
            rd0 = obs0.size();
        end else passed++;
        checks++;
        if (stall_cnt0 - s0 != 5) $display("FAIL mret_stall_cycles: got %0d, expected 5", stall_cnt0 - s0);
        else passed++;
        rd1 = obs1.size();
    endtask

    task automatic test_priority_and_invalid();
        int acc, s0;
        ev_t e, o;
        set_models(32'h0000_0201, 32'h0000_0008, 32'h0);
        s0 = stall_cnt0;
        issue(32'h0000_0080, 32'h1234_5678, 4'b1010, acc);
        exp_trap(1'b0, 32'h80, 4'd2, 32'h1234_5678, 32'h201, 32'h8, acc);
        repeat (8) @(posedge clk); #1;
        {ill, ebreak, ecall, mret} = 4'b1111;
        pc = 32'h0000_0500;
        repeat (5) @(posedge clk); #1;
        {ill, ebreak, ecall, mret} = 4'b0000;
        repeat (2) @(posedge clk); #1;
        while (exp0.size() > 0) begin
            e = exp0.pop_front(); checks++;
            if (rd0 >= obs0.size())
                $display("FAIL priority_event: got none, expected kind=%b csr=%h data=%h cyc=%0d", e.kind, e.num, e.data, e.cyc);
            else begin
                o = obs0[rd0]; rd0++;
                if (o !== e) $display("FAIL priority_event: got kind=%b csr=%h data=%h cyc=%0d te=%b, expected kind=%b csr=%h data=%h cyc=%0d te=%b",
                                      o.kind, o.num, o.data, o.cyc, o.te, e.kind, e.num, e.data, e.cyc, e.te);
                else passed++;
            end
        end
        checks++;
        if (obs0.size() != rd0) begin
            $display("FAIL invalid_flags_events: got %0d extra events, expected 0", obs0.size() - rd0);
            rd0 = obs0.size();
        end else passed++;
        checks++;
        if (stall_cnt0 - s0 != 8) $display("FAIL invalid_flags_stall: got %0d stall cycles, expected 8", stall_cnt0 - s0);
        else passed++;
        rd1 = obs1.size();
    endtask

    task automatic test_reset_mid();
        int acc;
        ev_t e, o;
        set_models(32'h0000_0201, 32'h0000_0008, 32'h0);
        issue(32'h0000_0100, 32'h0000_0073, 4'b0010, acc);
        exp0.push_back(ev(K_RD, 12'h305, 32'h0, acc + 1, 1'b0));
        exp0.push_back(ev(K_WR, 12'h341, 32'h100, acc + 2, 1'b0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({stall, re, we, redir, te, num, wdata, rpc} !== '0)
            $display("FAIL reset_mid_outputs: got %h, expected 0", {stall, re, we, redir, te, num, wdata, rpc});
        else passed++;
        repeat (10) @(posedge clk); #1;
        while (exp0.size() > 0) begin
            e = exp0.pop_front(); checks++;
            if (rd0 >= obs0.size())
                $display("FAIL reset_mid_event: got none, expected kind=%b csr=%h data=%h cyc=%0d", e.kind, e.num, e.data, e.cyc);
            else begin
                o = obs0[rd0]; rd0++;
                if (o !== e) $display("FAIL reset_mid_event: got kind=%b csr=%h data=%h cyc=%0d te=%b, expected kind=%b csr=%h data=%h cyc=%0d te=%b",
                                      o.kind, o.num, o.data, o.cyc, o.te, e.kind, e.num, e.data, e.cyc, e.te);
                else passed++;
            end
        end
        checks++;
        if (obs0.size() != rd0) begin
            $display("FAIL reset_mid_extra: got %0d events after reset, expected 0", obs0.size() - rd0);
            rd0 = obs0.size();
        end else passed++;
        rd1 = obs1.size();
    endtask

    task automatic test_back_to_back();
        int acc, acc2, s0;
        ev_t e, o;
        set_models(32'h0000_0201, 32'h0000_1880, 32'h0000_0107);
        s0 = stall_cnt0;
        issue(32'h0000_0200, 32'h3020_0073, 4'b0001, acc);
        exp_mret(1'b0, 32'h107, 32'h1880, acc);
        repeat (3) @(posedge clk);
        issue(32'h0000_02F0, 32'h0010_0073, 4'b0100, acc2);
        exp_trap(1'b0, 32'h2F0, 4'd3, 32'h2F0, 32'h201, exp_ms_mret(32'h1880), acc + 5);
        repeat (10) @(posedge clk); #1;
        while (exp0.size() > 0) begin
            e = exp0.pop_front(); checks++;
            if (rd0 >= obs0.size())
                $display("FAIL b2b_event: got none, expected kind=%b csr=%h data=%h cyc=%0d", e.kind, e.num, e.data, e.cyc);
            else begin
                o = obs0[rd0]; rd0++;
                if (o !== e) $display("FAIL b2b_event: got kind=%b csr=%h data=%h cyc=%0d te=%b, expected kind=%b csr=%h data=%h cyc=%0d te=%b",
                                      o.kind, o.num, o.data, o.cyc, o.te, e.kind, e.num, e.data, e.cyc, e.te);
                else passed++;
            end
        end
        checks++;
        if (obs0.size() != rd0) begin
            $display("FAIL b2b_extra: got %0d extra events, expected 0", obs0.size() - rd0);
            rd0 = obs0.size();
        end else passed++;
        checks++;
        if (stall_cnt0 - s0 != 13) $display("FAIL b2b_stall_cycles: got %0d, expected 13", stall_cnt0 - s0);
        else passed++;
        rd1 = obs1.size();
    endtask

    initial begin
        test_reset();
        test_ecall();
        test_illegal();
        test_mret();
        test_priority_and_invalid();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
